// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, scheduler state type and frame length helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    // Start bit + data bits + optional parity + one or two stop bits.
    function automatic logic [3:0] frame_len(input logic dnum, input logic snum,
                                             input logic [1:0] par);
        logic [3:0] len;
        len = dnum ? 4'd10 : 4'd9;
        if (par == PAR_ODD || par == PAR_EVEN) begin
            len = len + 4'd1;
        end
        if (snum) begin
            len = len + 4'd1;
        end
        return len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       valid
);
    localparam int IDX_W = $clog2(NUM_REQ);

    int   cand;
    logic found;

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    assign valid = found;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant[gi] = found && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_TX_SCHED_PRIO0_EN to give requester 0 absolute priority.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MIN_GAP = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic                       cfg_dnum,
    input  logic                       cfg_snum,
    input  logic [1:0]                 cfg_par,
    input  logic [1:0]                 cfg_bd_rate,
    output logic [NUM_REQ-1:0]         ack,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    output logic                       tx_dnum,
    output logic                       tx_snum,
    output logic [1:0]                 tx_par,
    output logic [1:0]                 tx_bd_rate,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] cur_src,
    output logic                       frame_done
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    sched_state_t       state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   cur_src_q, cur_src_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               frame_done_q, frame_done_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_dnum_q, tx_dnum_d;
    logic               tx_snum_q, tx_snum_d;
    logic [1:0]         tx_par_q, tx_par_d;
    logic [1:0]         tx_bd_rate_q, tx_bd_rate_d;

    logic [7:0]         src_byte [NUM_REQ];
    logic [NUM_REQ-1:0] arb_req, arb_grant, grant_onehot;
    logic [IDX_W-1:0]   arb_idx, grant_idx;
    logic               arb_valid, grant_valid, advance_ptr;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src_byte
            assign src_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

`ifdef UART_TX_SCHED_PRIO0_EN
    // Requester 0 bypasses the rotation; the others rotate among themselves.
    assign arb_req      = {req[NUM_REQ-1:1], 1'b0};
    assign grant_valid  = req[0] | arb_valid;
    assign grant_idx    = req[0] ? '0 : arb_idx;
    assign grant_onehot = req[0] ? NUM_REQ'(1) : arb_grant;
    assign advance_ptr  = ~req[0];
`else
    assign arb_req      = req;
    assign grant_valid  = arb_valid;
    assign grant_idx    = arb_idx;
    assign grant_onehot = arb_grant;
    assign advance_ptr  = 1'b1;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (arb_req),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        rr_ptr_d     = rr_ptr_q;
        cur_src_d    = cur_src_q;
        ack_d        = '0;
        frame_done_d = 1'b0;
        tx_data_d    = tx_data_q;
        tx_dnum_d    = tx_dnum_q;
        tx_snum_d    = tx_snum_q;
        tx_par_d     = tx_par_q;
        tx_bd_rate_d = tx_bd_rate_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    ack_d        = grant_onehot;
                    cur_src_d    = grant_idx;
                    tx_data_d    = src_byte[grant_idx];
                    tx_dnum_d    = cfg_dnum;
                    tx_snum_d    = cfg_snum;
                    tx_par_d     = cfg_par;
                    tx_bd_rate_d = cfg_bd_rate;
                    // Frame length comes from the same cfg snapshot the transmitter sees.
                    cnt_d        = frame_len(cfg_dnum, cfg_snum, cfg_par) - 4'd1;
                    if (advance_ptr) begin
                        rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                      : grant_idx + 1'b1;
                    end
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_GAP;
                    frame_done_d = 1'b1;
                    gap_d        = GAP_W'(MIN_GAP - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gap_q        <= '0;
            rr_ptr_q     <= '0;
            cur_src_q    <= '0;
            ack_q        <= '0;
            frame_done_q <= 1'b0;
            tx_data_q    <= '0;
            tx_dnum_q    <= 1'b0;
            tx_snum_q    <= 1'b0;
            tx_par_q     <= '0;
            tx_bd_rate_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_src_q    <= cur_src_d;
            ack_q        <= ack_d;
            frame_done_q <= frame_done_d;
            tx_data_q    <= tx_data_d;
            tx_dnum_q    <= tx_dnum_d;
            tx_snum_q    <= tx_snum_d;
            tx_par_q     <= tx_par_d;
            tx_bd_rate_q <= tx_bd_rate_d;
        end
    end

    assign tx_start   = (state_q == ST_SEND);
    assign busy       = (state_q != ST_IDLE);
    assign ack        = ack_q;
    assign cur_src    = cur_src_q;
    assign frame_done = frame_done_q;
    assign tx_data    = tx_data_q;
    assign tx_dnum    = tx_dnum_q;
    assign tx_snum    = tx_snum_q;
    assign tx_par     = tx_par_q;
    assign tx_bd_rate = tx_bd_rate_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (NUM_REQ=4, MIN_GAP=1) with hand-computed expectations.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        cfg_dnum, cfg_snum;
    logic [1:0]  cfg_par, cfg_bd_rate;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_start, tx_dnum, tx_snum;
    logic [1:0]  tx_par, tx_bd_rate;
    logic        busy;
    logic [1:0]  cur_src;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    uart_tx_scheduler #(
        .NUM_REQ (4),
        .MIN_GAP (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .cfg_dnum    (cfg_dnum),
        .cfg_snum    (cfg_snum),
        .cfg_par     (cfg_par),
        .cfg_bd_rate (cfg_bd_rate),
        .ack         (ack),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_dnum     (tx_dnum),
        .tx_snum     (tx_snum),
        .tx_par      (tx_par),
        .tx_bd_rate  (tx_bd_rate),
        .busy        (busy),
        .cur_src     (cur_src),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Raise req, let the IDLE edge sample it, check the grant cycle, then drop req.
    task automatic grant(input logic [3:0] reqv, input logic [3:0] exp_ack,
                         input logic [1:0] exp_src, input string tag);
        req = reqv;
        tick();
        check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_start"}, 32'(tx_start), 32'd1);
        check({tag, "_src"}, 32'(cur_src), 32'(exp_src));
        req = 4'b0000;
        $display("grant %s: req=%b ack=%b cur_src=%0d", tag, reqv, ack, cur_src);
    endtask

    // Count remaining tx_start-high cycles, then check the fall, gap and return to idle.
    task automatic run_frame(input int already, input int exp_len, input string tag);
        int n;
        n = 0;
        while (tx_start === 1'b1 && n < 64) begin
            n++;
            tick();
            check({tag, "_ack_pulse"}, 32'(ack), 32'd0);
        end
        check({tag, "_len"}, 32'(already + n), 32'(exp_len));
        check({tag, "_frame_done"}, 32'(frame_done), 32'd1);
        tick();
        check({tag, "_frame_done_1cyc"}, 32'(frame_done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        $display("frame %s: tx_start high %0d cycles", tag, already + n);
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (ack == 4'b0000 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int last;
        logic [3:0] ack_or;
        rst = 1'b1; req = '0; req_data = '0;
        cfg_dnum = 1'b1; cfg_snum = 1'b0; cfg_par = 2'b00; cfg_bd_rate = 2'b00;
        repeat (3) tick();
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_src", 32'(cur_src), 32'd0);
        check("rst_cfg", 32'({tx_dnum, tx_snum, tx_par, tx_bd_rate}), 32'd0);
        rst = 1'b0;
        tick();

        // Single source, 8N1: L = 10.
        req_data = 32'h0000_A500; cfg_bd_rate = 2'b10;
        grant(4'b0010, 4'b0010, 2'd1, "single");
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_bd", 32'(tx_bd_rate), 32'd2);
        check("single_dnum", 32'(tx_dnum), 32'd1);
        run_frame(0, 10, "single");

        // 8 data, odd parity, 2 stop: L = 12.
        req_data = 32'h0000_003C; cfg_par = 2'b01; cfg_snum = 1'b1;
        grant(4'b0001, 4'b0001, 2'd0, "par_odd");
        check("par_odd_data", 32'(tx_data), 32'h3C);
        check("par_odd_par", 32'(tx_par), 32'd1);
        run_frame(0, 12, "par_odd");

        // 7 data, parity code 11 (none), 1 stop: L = 9.
        req_data = 32'h0077_0000; cfg_dnum = 1'b0; cfg_par = 2'b11; cfg_snum = 1'b0;
        grant(4'b0100, 4'b0100, 2'd2, "par_none11");
        check("par_none11_data", 32'(tx_data), 32'h77);
        run_frame(0, 9, "par_none11");

        // Config snapshot, plus a req[3] that drops before it can be granted.
        cfg_dnum = 1'b1; cfg_par = 2'b00; cfg_snum = 1'b0; req_data = 32'h0000_5A00;
        grant(4'b0010, 4'b0010, 2'd1, "snap");
        req = 4'b1000;
        tick(); tick();
        req = 4'b0000;
        tick();
        cfg_par = 2'b10; cfg_dnum = 1'b0; cfg_snum = 1'b1;
        tick();
        check("snap_par", 32'(tx_par), 32'd0);
        check("snap_dnum", 32'(tx_dnum), 32'd1);
        check("snap_snum", 32'(tx_snum), 32'd0);
        run_frame(4, 10, "snap");
        cfg_par = 2'b00; cfg_dnum = 1'b1; cfg_snum = 1'b0;
        ack_or = '0;
        repeat (3) begin
            tick();
            ack_or = ack_or | ack;
        end
        check("dropped_req_ack", 32'(ack_or), 32'd0);
        check("dropped_req_busy", 32'(busy), 32'd0);

        // Reset in the 5th SEND cycle; rr_ptr is 2 here, then 3 after this grant.
        req_data = 32'h00C3_0000;
        grant(4'b0100, 4'b0100, 2'd2, "midrst");
        repeat (4) tick();
        check("midrst_still_sending", 32'(tx_start), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_start", 32'(tx_start), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(tx_data), 32'd0);
        check("midrst_src", 32'(cur_src), 32'd0);
        check("midrst_cfg", 32'({tx_dnum, tx_snum, tx_par, tx_bd_rate}), 32'd0);
        rst = 1'b0;
        grant(4'b1100, 4'b0100, 2'd2, "post_rst");
        check("post_rst_data", 32'(tx_data), 32'hC3);
        run_frame(0, 10, "post_rst");

        rst = 1'b1; tick(); rst = 1'b0; tick();
`ifdef UART_TX_SCHED_PRIO0_EN
        req = 4'b1001;
        for (int g = 0; g < 3; g++) begin
            wait_ack("prio");
            check("prio_ack", 32'(ack), 32'd1);
            $display("prio grant %0d: ack=%b", g, ack);
            tick();
        end
        req = 4'b1000;
        wait_ack("prio_drop");
        check("prio_drop_ack", 32'(ack), 32'h8);
        $display("prio grant after drop: ack=%b", ack);
        req = 4'b0000;
`else
        req = 4'b1111;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ack("fair");
            check("fair_ack", 32'(ack), 32'(1 << (g % 4)));
            if (g > 0) check("fair_period", 32'(cyc - last), 32'd12);
            $display("fair grant %0d: ack=%b cycle=%0d", g, ack, cyc);
            last = cyc;
            tick();
        end
        req = 4'b0000;
`endif
        begin
            int n;
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check("final_idle", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
